// File: rtl/mem_access_unit.sv
// Load/store stage in front of a word-only data memory: one request at a time,
// sub-word stores as read-modify-write, sub-word loads extracted and extended.
module mem_access_unit #(
  parameter int unsigned ADDR_LIMIT = 512
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] ma,
  output logic [31:0] mwd,
  output logic        mwr,
  output logic        moe,
  input  logic [31:0] mrd
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;

  state_t      r_state;
  logic        r_ready;
  logic        r_resp_valid;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;

  logic        w_req_err;
  logic        w_word_st;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  always_comb begin
    w_req_err = 1'b0;
    case (req_size)
      2'b00:   w_req_err = 1'b0;
      2'b01:   w_req_err = req_addr[0];
      2'b10:   w_req_err = |req_addr[1:0];
      default: w_req_err = 1'b1;
    endcase
    if (req_addr >= ADDR_LIMIT) w_req_err = 1'b1;
  end

  assign w_word_st = r_we && (r_size == 2'b10);
  assign w_byte    = mrd[{r_addr[1:0], 3'b000} +: 8];
  assign w_half    = r_addr[1] ? mrd[31:16] : mrd[15:0];

  always_comb begin
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = mrd;
    endcase
  end

  always_comb begin
    w_merged = mrd;
    if (r_size == 2'b00)
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else if (r_addr[1])
      w_merged[31:16] = r_wdata[15:0];
    else
      w_merged[15:0] = r_wdata[15:0];
  end

  // Memory strobes decode from state so reset drops mwr without waiting for an edge.
  assign ma  = {r_addr[31:2], 2'b00};
  assign mwr = ((r_state == ACCESS) && w_word_st) || (r_state == MERGE_WR);
  assign moe = (r_state == ACCESS) && !w_word_st;

  always_comb begin
    mwd = '0;
    if (r_state == MERGE_WR)
      mwd = r_merge;
    else if ((r_state == ACCESS) && w_word_st)
      mwd = r_wdata;
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_ready      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
      r_we         <= 1'b0;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_merge      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && r_ready) begin
            r_we     <= req_we;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_ready  <= 1'b0;
            r_rdata  <= '0;
            if (w_req_err) begin
              r_err        <= 1'b1;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_state <= ACCESS;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        ACCESS: begin
          if (!r_we) begin
            r_rdata      <= w_load;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else if (w_word_st) begin
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_merge <= w_merged;
            r_state <= MERGE_WR;
          end
        end
        MERGE_WR: begin
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          r_resp_valid <= 1'b0;
          r_err        <= 1'b0;
          r_rdata      <= '0;
          r_ready      <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, backpressure, reset during a
// merge write, then random traffic against a byte-array reference model.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] ma;
  logic [31:0] mwd;
  logic        mwr;
  logic        moe;
  logic [31:0] mrd;

  mem_access_unit #(.ADDR_LIMIT(512)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .ma(ma), .mwd(mwd), .mwr(mwr), .moe(moe), .mrd(mrd)
  );

  always #5 clock = ~clock;

  // Word memory seen by the DUT
  logic [31:0] mem [256];
  logic        mem_clr = 1'b1;
  assign mrd = mem[ma[9:2]];
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mwr) begin
      mem[ma[9:2]] <= mwd;
    end
  end

  int unsigned resp_seen = 0;
  always @(negedge clock) if (resp_valid) resp_seen++;

  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory, plain arithmetic
  logic [7:0] ref_mem [1024];

  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
    int n;
    logic [31:0] v;
    err = (size == 2'd3) || ((addr % (32'd1 << size)) != 0) || (addr >= 32'd512);
    rdata = '0;
    lat = 1;
    if (!err) begin
      n = 1 << size;
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
        lat = (n == 4) ? 2 : 3;
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8*i));
        if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rdata = v;
        lat = 2;
      end
    end
  endtask

  // One request: handshake, then observe until resp_valid. Returns at posedge+1.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic [7:0] mwr_mask, output logic [7:0] moe_mask);
    bit acc;
    int waitc;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    acc = 0; waitc = 0;
    while (!acc && waitc < 20) begin
      @(negedge clock);
      acc = req_ready;
      waitc++;
    end
    if (!acc) check({tag, " accept timeout"}, 32'd0, 32'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0; rdata = '0; err = 1'b0; mwr_mask = '0; moe_mask = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (n < 8) begin
        mwr_mask[n] = mwr;
        moe_mask[n] = moe;
      end
      if (!mwr) check({tag, " mwd idle"}, mwd, 32'd0);
      check({tag, " ready busy"}, {31'd0, req_ready}, 32'd0);
      if (resp_valid) begin
        lat = n; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
    if (lat == 0) check({tag, " resp timeout"}, 32'd0, 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic check_op(input string tag, input logic we, input logic [1:0] size,
                          input logic [31:0] rdata, input logic err, input int lat,
                          input logic [7:0] mwr_mask, input logic [7:0] moe_mask,
                          input logic [31:0] e_rdata, input logic e_err, input int e_lat);
    logic [7:0] e_mwr, e_moe;
    e_mwr = '0; e_moe = '0;
    if (!e_err) begin
      if (!we) e_moe = 8'b010;
      else if (size == 2'd2) e_mwr = 8'b010;
      else begin e_moe = 8'b010; e_mwr = 8'b100; end
    end
    check({tag, " rdata"}, rdata, e_rdata);
    check({tag, " err"}, {31'd0, err}, {31'd0, e_err});
    check({tag, " latency"}, 32'(lat), 32'(e_lat));
    check({tag, " mwr cycles"}, {24'd0, mwr_mask}, {24'd0, e_mwr});
    check({tag, " moe cycles"}, {24'd0, moe_mask}, {24'd0, e_moe});
  endtask

  task automatic run_model(input string tag, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rd, erd; logic er, eer; int lt, elt; logic [7:0] mm, om;
    model(we, size, sgn, addr, wdata, erd, eer, elt);
    do_req(tag, we, size, sgn, addr, wdata, rd, er, lt, mm, om);
    check_op(tag, we, size, rd, er, lt, mm, om, erd, eer, elt);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_word;
  } vec_t;

  vec_t tv [17];

  initial begin
    logic [31:0] rd, mrd_dummy; logic er; int lt; logic [7:0] mm, om;
    logic        bp_we   [3];
    logic [1:0]  bp_size [3];
    logic [31:0] bp_addr [3];
    logic [31:0] bp_wd   [3];
    logic [31:0] bp_erd  [3];
    logic        bp_eer  [3];
    int          bp_elat [3];
    int          acc_cyc [3];
    logic [31:0] got_rd  [3];
    logic        got_err [3];
    int idx, rcount, cyc;
    bit acc;
    int unsigned seen0;

    tv[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2, 32'hDEADBEEF};
    tv[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2, 32'hDEADBEEF};
    tv[2]  = '{1'b1, 2'd0, 1'b0, 32'h11,  32'h000000AA, 32'h0,        1'b0, 3, 32'hDEADAAEF};
    tv[3]  = '{1'b0, 2'd0, 1'b1, 32'h11,  32'h0,        32'hFFFFFFAA, 1'b0, 2, 32'hDEADAAEF};
    tv[4]  = '{1'b0, 2'd0, 1'b0, 32'h11,  32'h0,        32'h000000AA, 1'b0, 2, 32'hDEADAAEF};
    tv[5]  = '{1'b1, 2'd1, 1'b0, 32'h12,  32'h00001234, 32'h0,        1'b0, 3, 32'h1234AAEF};
    tv[6]  = '{1'b0, 2'd1, 1'b1, 32'h12,  32'h0,        32'h00001234, 1'b0, 2, 32'h1234AAEF};
    tv[7]  = '{1'b0, 2'd1, 1'b1, 32'h10,  32'h0,        32'hFFFFAAEF, 1'b0, 2, 32'h1234AAEF};
    tv[8]  = '{1'b0, 2'd1, 1'b0, 32'h10,  32'h0,        32'h0000AAEF, 1'b0, 2, 32'h1234AAEF};
    tv[9]  = '{1'b1, 2'd0, 1'b0, 32'h13,  32'hFFFFFF80, 32'h0,        1'b0, 3, 32'h8034AAEF};
    tv[10] = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0, 2, 32'h8034AAEF};
    tv[11] = '{1'b0, 2'd2, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1, 1, 32'h8034AAEF};
    tv[12] = '{1'b1, 2'd1, 1'b0, 32'h11,  32'h0000FFFF, 32'h0,        1'b1, 1, 32'h8034AAEF};
    tv[13] = '{1'b1, 2'd3, 1'b0, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1, 1, 32'h8034AAEF};
    tv[14] = '{1'b1, 2'd2, 1'b0, 32'h200, 32'h11111111, 32'h0,        1'b1, 1, 32'h0};
    tv[15] = '{1'b1, 2'd2, 1'b0, 32'h1FC, 32'hCAFEF00D, 32'h0,        1'b0, 2, 32'hCAFEF00D};
    tv[16] = '{1'b0, 2'd2, 1'b1, 32'h1FC, 32'h0,        32'hCAFEF00D, 1'b0, 2, 32'hCAFEF00D};

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

    repeat (2) @(posedge clock);
    #1 mem_clr = 1'b0;
    @(negedge clock);
    check("reset req_ready", {31'd0, req_ready}, 32'd0);
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset resp_err", {31'd0, resp_err}, 32'd0);
    check("reset mwr/moe", {30'd0, mwr, moe}, 32'd0);
    check("reset ma", ma, 32'd0);
    check("reset mwd", mwd, 32'd0);
    #1 reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("ready after release", {31'd0, req_ready}, 32'd1);
    @(posedge clock);
    #1;

    for (int i = 0; i < 17; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      model(tv[i].we, tv[i].size, tv[i].sgn, tv[i].addr, tv[i].wdata, mrd_dummy, er, lt);
      do_req(tag, tv[i].we, tv[i].size, tv[i].sgn, tv[i].addr, tv[i].wdata, rd, er, lt, mm, om);
      check_op(tag, tv[i].we, tv[i].size, rd, er, lt, mm, om,
               tv[i].exp_rdata, tv[i].exp_err, tv[i].exp_lat);
      check({tag, " mem word"}, mem[tv[i].addr[9:2]], tv[i].exp_word);
    end

    // Backpressure: req_valid held while three requests queue up
    bp_we[0] = 1'b1; bp_size[0] = 2'd2; bp_addr[0] = 32'h20; bp_wd[0] = 32'h11223344;
    bp_we[1] = 1'b1; bp_size[1] = 2'd0; bp_addr[1] = 32'h21; bp_wd[1] = 32'h00000077;
    bp_we[2] = 1'b0; bp_size[2] = 2'd2; bp_addr[2] = 32'h20; bp_wd[2] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      model(bp_we[k], bp_size[k], 1'b0, bp_addr[k], bp_wd[k], bp_erd[k], bp_eer[k], bp_elat[k]);
      acc_cyc[k] = -1; got_rd[k] = '0; got_err[k] = 1'b1;
    end
    idx = 0; rcount = 0; cyc = 0;
    req_valid = 1'b1; req_we = bp_we[0]; req_size = bp_size[0]; req_signed = 1'b0;
    req_addr = bp_addr[0]; req_wdata = bp_wd[0];
    while (cyc < 40 && (idx < 3 || rcount < 3)) begin
      @(negedge clock);
      acc = req_valid && req_ready;
      if (resp_valid && rcount < 3) begin
        got_rd[rcount] = resp_rdata; got_err[rcount] = resp_err; rcount++;
      end
      @(posedge clock);
      #1;
      if (acc) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) begin
          req_we = bp_we[idx]; req_size = bp_size[idx];
          req_addr = bp_addr[idx]; req_wdata = bp_wd[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      cyc++;
    end
    req_valid = 1'b0;
    check("bp accepts", 32'(idx), 32'd3);
    check("bp responses", 32'(rcount), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp rdata%0d", k), got_rd[k], bp_erd[k]);
      check($sformatf("bp err%0d", k), {31'd0, got_err[k]}, {31'd0, bp_eer[k]});
      if (k > 0)
        check($sformatf("bp spacing%0d", k), 32'(acc_cyc[k] - acc_cyc[k-1]), 32'(bp_elat[k-1] + 1));
    end
    check("bp final word", mem[8], 32'h11227744);

    // Reset during MERGE_WR of a byte store
    run_model("pre-reset SW", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADAAEF);
    seen0 = resp_seen;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h55;
    acc = 0; cyc = 0;
    while (!acc && cyc < 20) begin
      @(negedge clock);
      acc = req_ready;
      cyc++;
    end
    if (!acc) check("rst accept timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    check("rst access moe", {31'd0, moe}, 32'd1);
    @(posedge clock);
    #2;
    check("rst merge mwr", {31'd0, mwr}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst mwr drops", {31'd0, mwr}, 32'd0);
    check("rst ready low", {31'd0, req_ready}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst word kept", mem[4], 32'hDEADAAEF);
    #1 reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rst ready after", {31'd0, req_ready}, 32'd1);
    check("rst no resp", resp_seen - seen0, 32'd0);
    @(posedge clock);
    #1;
    do_req("rst LW", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lt, mm, om);
    check_op("rst LW", 1'b0, 2'd2, rd, er, lt, mm, om, 32'hDEADAAEF, 1'b0, 2);

    // Random traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      logic we; logic [1:0] size; logic sgn; logic [31:0] addr, wdata;
      we    = 1'($urandom);
      sgn   = 1'($urandom);
      size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr  = ($urandom_range(0, 9) == 0) ? 32'h200 + $urandom_range(0, 255)
                                          : 32'h40 + $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1 && size != 2'd3) addr = addr & ~((32'd1 << size) - 1);
      wdata = $urandom;
      run_model($sformatf("rnd%0d", i), we, size, sgn, addr, wdata);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
